// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode/funct constants, ALU and mux encodings, controller state encoding
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_SE   = 2'b10;
  localparam logic [1:0] SRCB_SE_2 = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ_EX   = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_JUMP     = 4'd11
  } state_t;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps ALUOp class (add/sub/funct) and funct to the 3-bit ALU operation
//   alu_op_i [1:0] class, funct_i [5:0] instr[5:0], alu_ctrl_o [2:0] ALU operation
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctrl_o
);
  always_comb begin
    alu_ctrl_o = alu_op_i == ALUOP_ADD ? ALU_ADD :
                 alu_op_i == ALUOP_SUB ? ALU_SUB :
                 funct_i == F_SUB ? ALU_SUB :
                 funct_i == F_AND ? ALU_AND :
                 funct_i == F_OR  ? ALU_OR  :
                 funct_i == F_SLT ? ALU_SLT : ALU_ADD;
  end
endmodule

// File: rtl/mips_mc_controller.sv
// mips_mc_controller: multicycle MIPS control FSM driving datapath selects, strobes and alu_ctrl
//   in: clk, rst_n (async low), op, funct, zero, mem_ready
//   out: pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
//        alu_src_a, alu_src_b, pc_src, alu_ctrl, illegal_op, state_o (debug)
module mips_mc_controller
  import mips_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [2:0]         alu_ctrl,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o
);
  state_t state_q, state_d;
  logic [1:0] alu_op;
  logic rdy;
  // Strobes are gated by rst_n so nothing fires while reset is held, whatever mem_ready does.
  assign rdy = mem_ready & rst_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    pc_src     = PCSRC_ALU;
    alu_op     = ALUOP_ADD;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b = SRCB_4;
        ir_write  = rdy;
        pc_en     = rdy;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = SRCB_SE_2;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPE_EX;
          OP_BEQ:       state_d = S_BEQ_EX;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR, S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_SE;
        state_d   = state_q == S_ADDI_EX ? S_ADDI_WB : op == OP_SW ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = rdy;
        state_d   = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTYPE_EX: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ_EX: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_en     = zero & rst_n;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = PCSRC_JUMP;
        pc_en   = rst_n;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end
  alu_decoder u_alu_decoder (
    .alu_op_i   (alu_op),
    .funct_i    (funct),
    .alu_ctrl_o (alu_ctrl)
  );
  assign state_o = STATE_W'(state_q);
endmodule

// File: tb/tb_mips_mc_controller.sv
// tb_mips_mc_controller: directed self-checking bench for the multicycle controller
module tb_mips_mc_controller;
  logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] op = 6'd0, funct = 6'd0;
  logic pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctrl;
  logic [3:0] state_o;
  int errors = 0, checks = 0;
  localparam logic [3:0] FE = 4'd0, DE = 4'd1, MA = 4'd2, MR = 4'd3, MB = 4'd4, MW = 4'd5,
                         RE = 4'd6, RW = 4'd7, BE = 4'd8, AE = 4'd9, AW = 4'd10, JP = 4'd11;
  always #5 clk = ~clk;
  mips_mc_controller #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .alu_ctrl(alu_ctrl), .illegal_op(illegal_op), .state_o(state_o)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic nxt;
    @(negedge clk);
    #1;
  endtask
  initial begin
    mem_ready = 1'b1;
    #1;
    chk("rst_state", 32'(state_o), 32'(FE));
    chk("rst_pc_en", 32'(pc_en), 0);
    chk("rst_ir_write", 32'(ir_write), 0);
    chk("rst_src_b", 32'(alu_src_b), 1);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 3'b010);
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("wait_state", 32'(state_o), 32'(FE));
      chk("wait_pc_en", 32'(pc_en), 0);
      chk("wait_ir_write", 32'(ir_write), 0);
      nxt();
    end
    mem_ready = 1'b1;
    op = 6'b000000;
    funct = 6'b100010;
    #1;
    chk("fetch_ir_write", 32'(ir_write), 1);
    chk("fetch_pc_en", 32'(pc_en), 1);
    nxt();
    chk("rt_decode", 32'(state_o), 32'(DE));
    chk("rt_dec_src_b", 32'(alu_src_b), 3);
    chk("rt_dec_illegal", 32'(illegal_op), 0);
    nxt();
    chk("rt_ex_state", 32'(state_o), 32'(RE));
    chk("rt_ex_alu", 32'(alu_ctrl), 3'b110);
    chk("rt_ex_src_a", 32'(alu_src_a), 1);
    chk("rt_ex_src_b", 32'(alu_src_b), 0);
    nxt();
    chk("rt_wb_state", 32'(state_o), 32'(RW));
    chk("rt_wb_reg_write", 32'(reg_write), 1);
    chk("rt_wb_reg_dst", 32'(reg_dst), 1);
    nxt();
    chk("rt_done", 32'(state_o), 32'(FE));
    op = 6'b000100;
    zero = 1'b1;
    nxt(); nxt();
    chk("beq1_state", 32'(state_o), 32'(BE));
    chk("beq1_pc_en", 32'(pc_en), 1);
    chk("beq1_pc_src", 32'(pc_src), 1);
    chk("beq1_alu", 32'(alu_ctrl), 3'b110);
    nxt();
    chk("beq1_done", 32'(state_o), 32'(FE));
    zero = 1'b0;
    nxt(); nxt();
    chk("beq0_state", 32'(state_o), 32'(BE));
    chk("beq0_pc_en", 32'(pc_en), 0);
    nxt();
    chk("beq0_done", 32'(state_o), 32'(FE));
    op = 6'b100011;
    nxt(); nxt();
    chk("lw_adr_state", 32'(state_o), 32'(MA));
    chk("lw_adr_src_b", 32'(alu_src_b), 2);
    mem_ready = 1'b0;
    nxt();
    for (int i = 0; i < 2; i++) begin
      chk("lw_rd_wait_state", 32'(state_o), 32'(MR));
      chk("lw_rd_wait_iord", 32'(iord), 1);
      nxt();
    end
    mem_ready = 1'b1;
    #1;
    chk("lw_rd_ready_iord", 32'(iord), 1);
    nxt();
    chk("lw_wb_state", 32'(state_o), 32'(MB));
    chk("lw_wb_mem_to_reg", 32'(mem_to_reg), 1);
    chk("lw_wb_reg_write", 32'(reg_write), 1);
    nxt();
    chk("lw_done", 32'(state_o), 32'(FE));
    op = 6'b101011;
    nxt(); nxt();
    mem_ready = 1'b0;
    nxt();
    chk("sw_wr_state", 32'(state_o), 32'(MW));
    chk("sw_wait_mem_write", 32'(mem_write), 0);
    chk("sw_wait_iord", 32'(iord), 1);
    mem_ready = 1'b1;
    #1;
    chk("sw_ready_mem_write", 32'(mem_write), 1);
    nxt();
    chk("sw_done", 32'(state_o), 32'(FE));
    chk("sw_after_mem_write", 32'(mem_write), 0);
    op = 6'b001000;
    nxt(); nxt();
    chk("addi_ex_state", 32'(state_o), 32'(AE));
    chk("addi_ex_src_a", 32'(alu_src_a), 1);
    nxt();
    chk("addi_wb_state", 32'(state_o), 32'(AW));
    chk("addi_wb_reg_write", 32'(reg_write), 1);
    chk("addi_wb_reg_dst", 32'(reg_dst), 0);
    nxt();
    op = 6'b000010;
    nxt(); nxt();
    chk("j_state", 32'(state_o), 32'(JP));
    chk("j_pc_en", 32'(pc_en), 1);
    chk("j_pc_src", 32'(pc_src), 2);
    nxt();
    chk("j_done", 32'(state_o), 32'(FE));
    op = 6'b111111;
    nxt();
    chk("ill_illegal", 32'(illegal_op), 1);
    chk("ill_reg_write", 32'(reg_write), 0);
    nxt();
    chk("ill_next_state", 32'(state_o), 32'(FE));
    chk("ill_pulse_end", 32'(illegal_op), 0);
    op = 6'b101011;
    nxt(); nxt();
    mem_ready = 1'b0;
    nxt();
    chk("rstmw_state", 32'(state_o), 32'(MW));
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rstmw_fetch", 32'(state_o), 32'(FE));
    chk("rstmw_mem_write", 32'(mem_write), 0);
    chk("rstmw_ir_write", 32'(ir_write), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
